// File: rtl/rf_seq_pkg.sv
// Shared command and state encodings for the register-file sequencer.
package rf_seq_pkg;

  typedef enum logic [1:0] {
    OP_FILL  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_SCAN  = 2'b10,
    OP_STOP  = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_CLEAR = 2'b10,
    ST_SCAN  = 2'b11
  } state_t;

endpackage

// File: rtl/rf_sequencer_if.sv
// Command handshake plus register-file write/read-address bus of the sequencer.
interface rf_sequencer_if import rf_seq_pkg::*; #(
  parameter int N = 4,
  parameter int W = 8
);

  logic          cmd_valid;
  cmd_op_t       cmd_op;
  logic          cmd_ready;
  logic [W-1:0]  rand_val;
  logic          we;
  logic [N-1:0]  addr_rd;
  logic [W-1:0]  data_in;
  logic [N-1:0]  addr_rs1;
  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd_op, rand_val,
    input  cmd_ready, we, addr_rd, data_in, addr_rs1, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, rand_val,
    output cmd_ready, we, addr_rd, data_in, addr_rs1, busy, done
  );

endinterface

// File: rtl/rf_sequencer_dwell_tick.sv
// Modulo-DWELL cycle counter; tick marks the last cycle of each dwell period.
module dwell_tick #(
  parameter int DWELL   = 100_000_000,
  parameter int DWELL_W = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

  logic [DWELL_W-1:0] cnt;

  assign tick = !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rf_sequencer.sv
// Sequencer that fills/clears a register file and scans its read address.
module rf_sequencer import rf_seq_pkg::*; #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int DWELL   = 100_000_000,
  parameter int DWELL_W = 27
) (
  input  logic           clk,
  input  logic           rst_n,
  rf_sequencer_if.slave  bus
);

  state_t       state;
  logic [N:0]   idx;
  logic         accept;
  logic         scan_clr;
  logic         tick;

  assign bus.busy      = (state != ST_IDLE);
  assign bus.cmd_ready = (state == ST_IDLE) || (state == ST_SCAN);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // Any accepted command (including SCAN in SCAN) restarts the dwell and suppresses the tick.
  assign scan_clr = (state != ST_SCAN) || accept;

  dwell_tick #(
    .DWELL   (DWELL),
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (scan_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      bus.we       <= 1'b0;
      bus.addr_rd  <= '0;
      bus.data_in  <= '0;
      bus.addr_rs1 <= '0;
      bus.done     <= 1'b0;
    end else begin
      bus.we   <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        ST_IDLE, ST_SCAN: begin
          if (tick) begin
            bus.addr_rs1 <= bus.addr_rs1 + 1'b1;
          end
          if (accept) begin
            idx <= '0;
            case (bus.cmd_op)
              OP_FILL:  state <= ST_FILL;
              OP_CLEAR: state <= ST_CLEAR;
              OP_SCAN:  state <= ST_SCAN;
              default:  state <= ST_IDLE;
            endcase
          end
        end
        ST_FILL, ST_CLEAR: begin
          // idx[N] set means all 2^N writes are out; this extra cycle carries done.
          if (!idx[N]) begin
            bus.we      <= 1'b1;
            bus.addr_rd <= idx[N-1:0];
            bus.data_in <= (state == ST_FILL) ? bus.rand_val : '0;
            idx         <= idx + 1'b1;
          end else begin
            bus.done <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
